sprite_renderer: RTL and testbench
==================================

// Module: sprite_renderer
// PURPOSE
// - Consumes the sprite position produced by the sprite movement block and turns it into per-pixel output.
// - Each line, it fetches one sprite bitmap row from the sprite ROM via a req/ack handshake in hblank.
// - During the active line, it shifts that row out as a 1-bit pixel stream aligned to the scaled pixel counter.
// - Sits between the movement block / sprite ROM and the colour mux in the VGA output path.
// PARAMETERS
// - SPRITE_WIDTH   16  sprite width in scaled pixels (= rom_data width)
// - SPRITE_HEIGHT  16  sprite height in scaled lines (ROM depth)
// - WIDTH_SMALL   160  scaled window width
// - HEIGHT_SMALL  120  scaled window height
// PORTS
// - clk            in   1   clock
// - reset_n        in   1   reset, asynchronous, active low
// - sprite_x       in   8   sprite left column (scaled), from movement block
// - sprite_y       in   8   sprite top line (scaled), from movement block
// - line_start     in   1   1-cycle pulse at start of hblank preceding line next_y
// - next_y         in   8   scaled line about to be displayed; valid with line_start
// - pixel_valid    in   1   strobe: pixel_x advanced to a new scaled pixel of active line
// - pixel_x        in   8   current scaled column; valid with pixel_valid
// - rom_req        out  1   ROM read request
// - rom_addr       out  $clog2(SPRITE_HEIGHT)  sprite row index
// - rom_ack        in   1   ROM data valid, 1-cycle pulse
// - rom_data       in   SPRITE_WIDTH  row bitmap, MSB = leftmost pixel
// - sprite_active  out  1   current pixel lies inside sprite box
// - sprite_pixel   out  1   bitmap bit for current pixel (0 when !sprite_active)
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, row_buf 0, row_valid 0, latched x/y 0.
// - On line_start, latch sprite_x/sprite_y into x_l/y_l (no tearing mid-line).
// - Same line_start: row = next_y - sprite_y (8-bit wrap).
// - row < SPRITE_HEIGHT -> FETCH; else row_valid <= 0, stay IDLE.
// - FSM IDLE -> FETCH -> READY:
//   - FETCH: rom_req=1, rom_addr=row[ADDR-1:0], both stable until rom_ack.
//   - On rom_ack: row_buf <= rom_data, row_valid <= 1, rom_req <= 0 same edge, go READY.
// - READY -> IDLE on next line_start; the new fetch decision is taken in that same cycle.
// - line_start while in FETCH: abort. rom_req drops for >=1 cycle, row_valid <= 0, then re-evaluate.
//   - This is a new fetch if in range; a late ack from the aborted request is ignored.
// - rom_ack outside FETCH: ignored.
// - Display, on pixel_valid:
//   - row_valid && pixel_x == x_l: load shifter with row_buf, cnt <= SPRITE_WIDTH-1, active.
//   - Else while active: shift left 1, decrement cnt; active clears after the cnt==0 pixel.
// - Outputs are registered, 1 clk after the pixel_valid strobe. Both hold between strobes.
//   - sprite_active = shifter running.
//   - sprite_pixel = shifter MSB & sprite_active.
// - Right edge: x_l+SPRITE_WIDTH > WIDTH_SMALL -> pixels past the last column are never strobed.
//   - The shifter is cleared by the next line_start; there is no wrap to the next line.
// - Bottom edge: rows beyond HEIGHT_SMALL are never requested because next_y stops there.
// - line_start clears the shifter and sprite_active immediately (next edge).
// - Simultaneous pixel_valid and line_start: line_start wins.
// - Mid-operation reset: async clear to reset state; rom_req deasserts immediately.
// STRUCTURE
// - sprite_pkg:
//   - typedef enum logic [1:0] {IDLE, FETCH, READY} spr_state_t;
//   - localparam defaults for SPRITE_WIDTH/HEIGHT, WIDTH_SMALL/HEIGHT_SMALL, shared with sprite_movement.
// - Sub-module sprite_row_shifter:
//   - ports: load, shift, din[SPRITE_WIDTH], pixel, active, clear.
//   - holds the shift register and pixel counter.
// - Top level holds the FSM, position latches, row compare and ROM handshake.
// TESTING
// - Reset, then line_start next_y=5, sprite_y=0:
//   -> rom_req=1, rom_addr=5; ack with 16'hF00F -> rom_req=0, row_valid=1.
// - sprite_x=10, strobe pixel_x 0..159:
//   -> sprite_active=1 for x=10..25 only; sprite_pixel=1 for x=10..13 and x=22..25.
// - next_y=3, sprite_y=8 (row wraps to 251):
//   -> no rom_req, sprite_active stays 0 for whole line.
// - Hold rom_ack low, pulse line_start again with in-range row:
//   -> rom_req drops >=1 cycle, re-asserts with new rom_addr.
//   -> a stale ack during the drop is ignored; row_valid=0.
// - sprite_x=150:
//   -> active for x=150..159 only (10 px); next line_start -> sprite_active=0, no leakage.
// - Assert reset_n=0 during FETCH:
//   -> rom_req, sprite_active, sprite_pixel all 0 asynchronously, FSM IDLE.
//   -> sprite_x changing mid-line does not move the current line's output.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite types and default geometry for the sprite renderer and the movement block.
// Window sizes are in scaled pixels.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } spr_state_t;

    localparam int SPRITE_WIDTH_DEF  = 16;
    localparam int SPRITE_HEIGHT_DEF = 16;
    localparam int WIDTH_SMALL_DEF   = 160;
    localparam int HEIGHT_SMALL_DEF  = 120;

    // A line is covered by the sprite when its wrapped distance below the top is under the height.
    function automatic logic row_hit(input logic [7:0] row, input int height);
        return row < 8'(height);
    endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Sprite ROM read port: a level request with a stable address, answered by a one-cycle
// acknowledge that carries the bitmap row.
interface sprite_renderer_if #(
    parameter int SPRITE_WIDTH  = sprite_pkg::SPRITE_WIDTH_DEF,
    parameter int SPRITE_HEIGHT = sprite_pkg::SPRITE_HEIGHT_DEF
);
    localparam int ADDR_W = $clog2(SPRITE_HEIGHT);

    logic                    rom_req;
    logic [ADDR_W-1:0]       rom_addr;
    logic                    rom_ack;
    logic [SPRITE_WIDTH-1:0] rom_data;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );
endinterface

// File: rtl/sprite_row_shifter.sv
// Shifts one sprite bitmap row out MSB first, one bit per shift strobe.
// The active flag stays set for exactly SPRITE_WIDTH pixels after a load.
module sprite_row_shifter #(
    parameter int SPRITE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    shift,
    input  logic                    clear,
    input  logic [SPRITE_WIDTH-1:0] din,
    output logic                    pixel,
    output logic                    active
);
    localparam int CNT_W = $clog2(SPRITE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SPRITE_WIDTH - 1);

    logic [SPRITE_WIDTH-1:0] shreg_reg;
    logic [SPRITE_WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    active_reg;

    assign shreg_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < SPRITE_WIDTH; gi++) begin : g_shift
            assign shreg_next[gi] = shreg_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (clear) begin
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            shreg_reg  <= din;
            cnt_reg    <= CNT_INIT;
            active_reg <= 1'b1;
        end else if (shift && active_reg) begin
            shreg_reg <= shreg_next;
            // The pixel shown while cnt is zero is the last one of the row.
            if (cnt_reg == '0) begin
                active_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign active = active_reg;
    assign pixel  = shreg_reg[SPRITE_WIDTH-1] & active_reg;

endmodule

// File: rtl/sprite_renderer.sv
// Fetches the sprite row for the upcoming line during hblank and streams it out as a
// 1-bit pixel mask aligned to the scaled pixel strobe.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH  = SPRITE_WIDTH_DEF,
    parameter int SPRITE_HEIGHT = SPRITE_HEIGHT_DEF,
    parameter int WIDTH_SMALL   = WIDTH_SMALL_DEF,
    parameter int HEIGHT_SMALL  = HEIGHT_SMALL_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         sprite_x,
    input  logic [7:0]         sprite_y,
    input  logic               line_start,
    input  logic [7:0]         next_y,
    input  logic               pixel_valid,
    input  logic [7:0]         pixel_x,
    sprite_renderer_if.master  rom,
    output logic               sprite_active,
    output logic               sprite_pixel
);
    localparam int ADDR_W = $clog2(SPRITE_HEIGHT);

    spr_state_t              state_reg;
    logic [7:0]              x_l_reg;
    logic [7:0]              y_l_reg;
    logic [7:0]              line_y_reg;
    logic                    row_valid_reg;
    logic                    refetch_reg;
    logic                    rom_req_reg;
    logic [ADDR_W-1:0]       rom_addr_reg;
    logic [SPRITE_WIDTH-1:0] row_buf_reg;

    logic [7:0] row;
    logic [7:0] refetch_row;
    logic       fetch_ok;
    logic       refetch_ok;
    logic       shift_load;
    logic       shift_step;

    assign row         = next_y - sprite_y;
    assign refetch_row = line_y_reg - y_l_reg;
    assign fetch_ok    = (next_y < 8'(HEIGHT_SMALL)) && row_hit(row, SPRITE_HEIGHT);
    assign refetch_ok  = refetch_reg && row_hit(refetch_row, SPRITE_HEIGHT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            x_l_reg       <= '0;
            y_l_reg       <= '0;
            line_y_reg    <= '0;
            row_valid_reg <= 1'b0;
            refetch_reg   <= 1'b0;
            rom_req_reg   <= 1'b0;
            rom_addr_reg  <= '0;
            row_buf_reg   <= '0;
        end else if (line_start) begin
            // Position is sampled only here so a moving sprite never tears mid-line.
            x_l_reg       <= sprite_x;
            y_l_reg       <= sprite_y;
            line_y_reg    <= next_y;
            row_valid_reg <= 1'b0;
            refetch_reg   <= 1'b0;
            if (state_reg == FETCH) begin
                // Abort: drop the request for a cycle and reissue from IDLE if still needed.
                rom_req_reg <= 1'b0;
                refetch_reg <= fetch_ok;
                state_reg   <= IDLE;
            end else if (fetch_ok) begin
                rom_req_reg  <= 1'b1;
                rom_addr_reg <= row[ADDR_W-1:0];
                state_reg    <= FETCH;
            end else begin
                state_reg <= IDLE;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (refetch_ok) begin
                        rom_req_reg  <= 1'b1;
                        rom_addr_reg <= refetch_row[ADDR_W-1:0];
                        state_reg    <= FETCH;
                    end
                    refetch_reg <= 1'b0;
                end
                FETCH: begin
                    if (rom.rom_ack) begin
                        row_buf_reg   <= rom.rom_data;
                        row_valid_reg <= 1'b1;
                        rom_req_reg   <= 1'b0;
                        state_reg     <= READY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rom.rom_req  = rom_req_reg;
    assign rom.rom_addr = rom_addr_reg;

    // line_start has priority over a coincident pixel strobe.
    assign shift_step = pixel_valid && !line_start;
    assign shift_load = shift_step && row_valid_reg && (pixel_x == x_l_reg)
                        && (pixel_x < 8'(WIDTH_SMALL));

    sprite_row_shifter #(
        .SPRITE_WIDTH(SPRITE_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (shift_load),
        .shift   (shift_step),
        .clear   (line_start),
        .din     (row_buf_reg),
        .pixel   (sprite_pixel),
        .active  (sprite_active)
    );

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: ROM handshake, pixel stream per line, edge cases.
module tb_sprite_renderer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] sprite_x = '0;
    logic [7:0] sprite_y = '0;
    logic       line_start = 1'b0;
    logic [7:0] next_y = '0;
    logic       pixel_valid = 1'b0;
    logic [7:0] pixel_x = '0;
    logic       sprite_active;
    logic       sprite_pixel;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sprite_renderer_if rom_bus ();

    sprite_renderer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .line_start    (line_start),
        .next_y        (next_y),
        .pixel_valid   (pixel_valid),
        .pixel_x       (pixel_x),
        .rom           (rom_bus.master),
        .sprite_active (sprite_active),
        .sprite_pixel  (sprite_pixel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input logic [7:0] ny);
        line_start = 1'b1;
        next_y     = ny;
        tick();
        line_start = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        rom_bus.rom_ack  = 1'b1;
        rom_bus.rom_data = d;
        tick();
        rom_bus.rom_ack  = 1'b0;
    endtask

    // Strobe a full line; optionally change sprite_x at column chg_at to prove no tearing.
    task automatic sweep(input logic [15:0] data, input int xs, input bit hit,
                         input int chg_at, input logic [7:0] new_x);
        bit exp_a;
        bit exp_p;
        for (int x = 0; x < 160; x++) begin
            if (x == chg_at) sprite_x = new_x;
            pixel_valid = 1'b1;
            pixel_x     = 8'(x);
            tick();
            exp_a = hit && (x >= xs) && (x < xs + 16);
            exp_p = 1'b0;
            if (exp_a) exp_p = data[15 - (x - xs)];
            check($sformatf("active x=%0d", x), {31'd0, sprite_active}, {31'd0, exp_a});
            check($sformatf("pixel x=%0d", x), {31'd0, sprite_pixel}, {31'd0, exp_p});
        end
        pixel_valid = 1'b0;
    endtask

    initial begin
        rom_bus.rom_ack  = 1'b0;
        rom_bus.rom_data = '0;
        tick();
        tick();
        check("reset rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
        check("reset active", {31'd0, sprite_active}, 32'd0);
        check("reset pixel", {31'd0, sprite_pixel}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic fetch and display of row 5.
        sprite_y = 8'd0;
        sprite_x = 8'd10;
        line(8'd5);
        check("fetch req", {31'd0, rom_bus.rom_req}, 32'd1);
        check("fetch addr", {28'd0, rom_bus.rom_addr}, 32'd5);
        tick();
        check("fetch req held", {31'd0, rom_bus.rom_req}, 32'd1);
        check("fetch addr held", {28'd0, rom_bus.rom_addr}, 32'd5);
        ack(16'hF00F);
        check("ack drops req", {31'd0, rom_bus.rom_req}, 32'd0);
        sweep(16'hF00F, 10, 1'b1, -1, 8'd0);

        // Row wraps to 251: no fetch, nothing shown.
        sprite_y = 8'd8;
        line(8'd3);
        check("wrap no req", {31'd0, rom_bus.rom_req}, 32'd0);
        tick();
        check("wrap no req later", {31'd0, rom_bus.rom_req}, 32'd0);
        sweep(16'h0, 10, 1'b0, -1, 8'd0);

        // Abort an outstanding fetch; stale ack in the drop cycle is ignored.
        sprite_y = 8'd0;
        sprite_x = 8'd150;
        line(8'd2);
        check("abort first req", {31'd0, rom_bus.rom_req}, 32'd1);
        check("abort first addr", {28'd0, rom_bus.rom_addr}, 32'd2);
        tick();
        line(8'd7);
        check("abort drop", {31'd0, rom_bus.rom_req}, 32'd0);
        ack(16'hFFFF);
        check("refetch req", {31'd0, rom_bus.rom_req}, 32'd1);
        check("refetch addr", {28'd0, rom_bus.rom_addr}, 32'd7);
        tick();
        check("stale ack ignored", {31'd0, rom_bus.rom_req}, 32'd1);
        ack(16'hA5C3);
        check("refetch ack", {31'd0, rom_bus.rom_req}, 32'd0);
        sweep(16'hA5C3, 150, 1'b1, -1, 8'd0);
        tick();
        check("right edge hold", {31'd0, sprite_active}, 32'd1);
        line(8'd100);
        check("right edge cleared", {31'd0, sprite_active}, 32'd0);
        check("out of range no req", {31'd0, rom_bus.rom_req}, 32'd0);
        sweep(16'h0, 150, 1'b0, -1, 8'd0);

        // sprite_x moves mid-line; current line keeps the latched column.
        sprite_x = 8'd20;
        line(8'd9);
        check("midline addr", {28'd0, rom_bus.rom_addr}, 32'd9);
        ack(16'h8001);
        sweep(16'h8001, 20, 1'b1, 5, 8'd60);

        // Reset asserted mid-cycle during FETCH.
        line(8'd4);
        check("pre-reset req", {31'd0, rom_bus.rom_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset req", {31'd0, rom_bus.rom_req}, 32'd0);
        check("async reset active", {31'd0, sprite_active}, 32'd0);
        check("async reset pixel", {31'd0, sprite_pixel}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        ack(16'hFFFF);
        check("post-reset idle req", {31'd0, rom_bus.rom_req}, 32'd0);
        pixel_valid = 1'b1;
        pixel_x     = 8'd0;
        sprite_x    = 8'd0;
        tick();
        pixel_valid = 1'b0;
        check("post-reset no row", {31'd0, sprite_active}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
